// File: rtl/hazard_stall_unit_pkg.sv
// Shared register-address width and FSM encodings for the ID-stage hazard/stall unit.
// Pure declarations; no timing or flow-control behaviour.
// Imported by hazard_stall_unit and hazard_match.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_TIMEOUT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Flags a true dependency of the ID instruction on one writing producer (register 0 never matches).
// Latency: purely combinational, zero cycles.
// Backpressure: none, it only feeds the stall decision.
module hazard_match
  import hazard_stall_unit_pkg::*;
(
  input  logic [REG_ADDR_LEN-1:0] SRC1_ID,
  input  logic [REG_ADDR_LEN-1:0] SRC2_ID,
  input  logic                    SRC2_VALID_ID,
  input  logic [REG_ADDR_LEN-1:0] DEST,
  input  logic                    WB_EN,
  output logic                    MATCH
);

  assign MATCH = WB_EN && (DEST != '0) &&
                 ((DEST == SRC1_ID) || (SRC2_VALID_ID && (DEST == SRC2_ID)));

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage interlock: load-use/RAW stalls, taken-branch flush, memory-busy freeze with watchdog.
// Latency: control outputs are combinational from state and inputs; counters update on CLK.
// Backpressure: MEM_BUSY freezes the whole pipe; hazards freeze PC/IF_ID and bubble ID_EXE.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MAX_MEM_WAIT = 16,
  parameter int CNT_W        = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [REG_ADDR_LEN-1:0] SRC1_ID,
  input  logic [REG_ADDR_LEN-1:0] SRC2_ID,
  input  logic                    SRC2_VALID_ID,
  input  logic [REG_ADDR_LEN-1:0] DEST_EXE,
  input  logic                    WRITE_BACK_EN_EXE,
  input  logic                    MEM_READ_EXE,
  input  logic [REG_ADDR_LEN-1:0] DEST_MEM,
  input  logic                    WRITE_BACK_EN_MEM,
  input  logic                    FORWARD_EN,
  input  logic                    BRANCH_TAKEN_EXE,
  input  logic                    MEM_BUSY,
  output logic                    PC_FREEZE,
  output logic                    IF_ID_FREEZE,
  output logic                    ID_EXE_BUBBLE,
  output logic                    FLUSH_IF_ID,
  output logic                    PIPE_FREEZE,
  output logic                    MEM_TIMEOUT,
  output logic [CNT_W-1:0]        STALL_CYCLES
);

  localparam int                WAIT_W    = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_MEM_WAIT - 1);

  hz_state_t         state_q, state_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  logic              timeout_q, timeout_set;
  logic [CNT_W-1:0]  stall_q;

  logic match_exe, match_mem, load_use, haz;
  logic run_eval;
  logic pc_frz, ifid_frz, bubble, flush, pipe_frz;

  hazard_match u_match_exe (
    .SRC1_ID       (SRC1_ID),
    .SRC2_ID       (SRC2_ID),
    .SRC2_VALID_ID (SRC2_VALID_ID),
    .DEST          (DEST_EXE),
    .WB_EN         (WRITE_BACK_EN_EXE),
    .MATCH         (match_exe)
  );

  hazard_match u_match_mem (
    .SRC1_ID       (SRC1_ID),
    .SRC2_ID       (SRC2_ID),
    .SRC2_VALID_ID (SRC2_VALID_ID),
    .DEST          (DEST_MEM),
    .WB_EN         (WRITE_BACK_EN_MEM),
    .MATCH         (match_mem)
  );

  // With forwarding only a load in EXE is uncoverable; without it any in-flight writer stalls.
  assign load_use = MEM_READ_EXE && match_exe;
  assign haz      = FORWARD_EN ? load_use : (match_exe || match_mem);

  always_comb begin
    state_nxt   = state_q;
    wait_nxt    = wait_q;
    timeout_set = 1'b0;
    run_eval    = 1'b0;
    pc_frz      = 1'b0;
    ifid_frz    = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    pipe_frz    = 1'b0;

    case (state_q)
      HZ_RUN: begin
        if (MEM_BUSY) begin
          state_nxt = HZ_MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        if (!MEM_BUSY) begin
          state_nxt = HZ_RUN;
          wait_nxt  = '0;
          run_eval  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_nxt   = HZ_TIMEOUT;
          timeout_set = 1'b1;
        end else begin
          wait_nxt = wait_q + WAIT_W'(1);
        end
      end
      HZ_TIMEOUT: begin
        if (!MEM_BUSY) begin
          state_nxt = HZ_RUN;
          wait_nxt  = '0;
          run_eval  = 1'b1;
        end
      end
      default: begin
        state_nxt = HZ_RUN;
        wait_nxt  = '0;
      end
    endcase

    if (MEM_BUSY) begin
      pipe_frz = 1'b1;
      pc_frz   = 1'b1;
      ifid_frz = 1'b1;
    end else if (run_eval) begin
      if (BRANCH_TAKEN_EXE) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (haz) begin
        pc_frz   = 1'b1;
        ifid_frz = 1'b1;
        bubble   = 1'b1;
      end
    end
  end

  assign PC_FREEZE     = pc_frz   && !RST;
  assign IF_ID_FREEZE  = ifid_frz && !RST;
  assign ID_EXE_BUBBLE = bubble   && !RST;
  assign FLUSH_IF_ID   = flush    && !RST;
  assign PIPE_FREEZE   = pipe_frz && !RST;
  assign MEM_TIMEOUT   = timeout_q;
  assign STALL_CYCLES  = stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HZ_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      if (timeout_set)
        timeout_q <= 1'b1;
      if (PC_FREEZE && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for the combinational stall/flush decision,
// plus sequences for interlock duration, memory wait, watchdog, mid-wait reset and counter saturation.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic       CLK;
  logic       RST;
  logic [4:0] SRC1_ID, SRC2_ID, DEST_EXE, DEST_MEM;
  logic       SRC2_VALID_ID, WRITE_BACK_EN_EXE, MEM_READ_EXE, WRITE_BACK_EN_MEM;
  logic       FORWARD_EN, BRANCH_TAKEN_EXE, MEM_BUSY;
  logic       PC_FREEZE, IF_ID_FREEZE, ID_EXE_BUBBLE, FLUSH_IF_ID, PIPE_FREEZE, MEM_TIMEOUT;
  logic [31:0] STALL_CYCLES;
  logic       s_pc, s_ifid, s_bub, s_flush, s_pipe, s_tmo;
  logic [3:0] s_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall;

  hazard_stall_unit dut (
    .CLK(CLK), .RST(RST), .SRC1_ID(SRC1_ID), .SRC2_ID(SRC2_ID), .SRC2_VALID_ID(SRC2_VALID_ID),
    .DEST_EXE(DEST_EXE), .WRITE_BACK_EN_EXE(WRITE_BACK_EN_EXE), .MEM_READ_EXE(MEM_READ_EXE),
    .DEST_MEM(DEST_MEM), .WRITE_BACK_EN_MEM(WRITE_BACK_EN_MEM), .FORWARD_EN(FORWARD_EN),
    .BRANCH_TAKEN_EXE(BRANCH_TAKEN_EXE), .MEM_BUSY(MEM_BUSY), .PC_FREEZE(PC_FREEZE),
    .IF_ID_FREEZE(IF_ID_FREEZE), .ID_EXE_BUBBLE(ID_EXE_BUBBLE), .FLUSH_IF_ID(FLUSH_IF_ID),
    .PIPE_FREEZE(PIPE_FREEZE), .MEM_TIMEOUT(MEM_TIMEOUT), .STALL_CYCLES(STALL_CYCLES)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  hazard_stall_unit #(.MAX_MEM_WAIT(16), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .SRC1_ID(SRC1_ID), .SRC2_ID(SRC2_ID), .SRC2_VALID_ID(SRC2_VALID_ID),
    .DEST_EXE(DEST_EXE), .WRITE_BACK_EN_EXE(WRITE_BACK_EN_EXE), .MEM_READ_EXE(MEM_READ_EXE),
    .DEST_MEM(DEST_MEM), .WRITE_BACK_EN_MEM(WRITE_BACK_EN_MEM), .FORWARD_EN(FORWARD_EN),
    .BRANCH_TAKEN_EXE(BRANCH_TAKEN_EXE), .MEM_BUSY(MEM_BUSY), .PC_FREEZE(s_pc),
    .IF_ID_FREEZE(s_ifid), .ID_EXE_BUBBLE(s_bub), .FLUSH_IF_ID(s_flush),
    .PIPE_FREEZE(s_pipe), .MEM_TIMEOUT(s_tmo), .STALL_CYCLES(s_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] src1, src2;
    logic       src2_v;
    logic [4:0] dexe;
    logic       wb_exe, rd_exe;
    logic [4:0] dmem;
    logic       wb_mem, fwd, br;
    logic       exp_frz, exp_bub, exp_flush;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    SRC1_ID = 0; SRC2_ID = 0; SRC2_VALID_ID = 0; DEST_EXE = 0; WRITE_BACK_EN_EXE = 0;
    MEM_READ_EXE = 0; DEST_MEM = 0; WRITE_BACK_EN_MEM = 0; FORWARD_EN = 1;
    BRANCH_TAKEN_EXE = 0; MEM_BUSY = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    exp_stall = 0;
  endtask

  // {PC_FREEZE, IF_ID_FREEZE, ID_EXE_BUBBLE, FLUSH_IF_ID, PIPE_FREEZE}
  function automatic logic [31:0] ctl();
    return {27'd0, PC_FREEZE, IF_ID_FREEZE, ID_EXE_BUBBLE, FLUSH_IF_ID, PIPE_FREEZE};
  endfunction

  initial begin
    RST = 1'b1;
    clear_inputs();

    //                src1 src2 v  dexe wb rd dmem wb fwd br   frz bub fl
    vecs[0]  = '{5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0,  0, 0, 0};
    vecs[1]  = '{5'd8, 5'd3, 1, 5'd8, 1, 1, 5'd0, 0, 1, 0,  1, 1, 0};
    vecs[2]  = '{5'd3, 5'd8, 0, 5'd8, 1, 1, 5'd0, 0, 1, 0,  0, 0, 0};
    vecs[3]  = '{5'd3, 5'd8, 1, 5'd8, 1, 1, 5'd0, 0, 1, 0,  1, 1, 0};
    vecs[4]  = '{5'd8, 5'd3, 1, 5'd8, 1, 0, 5'd0, 0, 1, 0,  0, 0, 0};
    vecs[5]  = '{5'd8, 5'd3, 1, 5'd8, 0, 1, 5'd0, 0, 1, 0,  0, 0, 0};
    vecs[6]  = '{5'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 1, 0,  0, 0, 0};
    vecs[7]  = '{5'd5, 5'd1, 1, 5'd5, 1, 0, 5'd0, 0, 0, 0,  1, 1, 0};
    vecs[8]  = '{5'd1, 5'd5, 1, 5'd9, 1, 0, 5'd5, 1, 0, 0,  1, 1, 0};
    vecs[9]  = '{5'd1, 5'd5, 1, 5'd9, 1, 0, 5'd5, 0, 0, 0,  0, 0, 0};
    vecs[10] = '{5'd0, 5'd0, 1, 5'd0, 1, 0, 5'd0, 1, 0, 0,  0, 0, 0};
    vecs[11] = '{5'd8, 5'd3, 1, 5'd8, 1, 1, 5'd0, 0, 1, 1,  0, 1, 1};
    vecs[12] = '{5'd2, 5'd3, 1, 5'd9, 1, 0, 5'd0, 0, 1, 1,  0, 1, 1};
    vecs[13] = '{5'd5, 5'd1, 1, 5'd5, 1, 0, 5'd0, 0, 0, 1,  0, 1, 1};
    vecs[14] = '{5'd1, 5'd5, 1, 5'd9, 1, 0, 5'd5, 1, 1, 0,  0, 0, 0};

    // Reset: controls forced low even with busy and a hazard presented.
    @(negedge CLK);
    MEM_BUSY = 1; BRANCH_TAKEN_EXE = 1;
    #1 chk("reset_ctl", ctl(), 32'd0);
    @(negedge CLK);
    clear_inputs();
    #1;
    chk("reset_stall_cycles", STALL_CYCLES, 32'd0);
    chk("reset_timeout", {31'd0, MEM_TIMEOUT}, 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(HZ_RUN));
    RST = 1'b0;
    exp_stall = 0;

    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      SRC1_ID = vecs[i].src1; SRC2_ID = vecs[i].src2; SRC2_VALID_ID = vecs[i].src2_v;
      DEST_EXE = vecs[i].dexe; WRITE_BACK_EN_EXE = vecs[i].wb_exe; MEM_READ_EXE = vecs[i].rd_exe;
      DEST_MEM = vecs[i].dmem; WRITE_BACK_EN_MEM = vecs[i].wb_mem; FORWARD_EN = vecs[i].fwd;
      BRANCH_TAKEN_EXE = vecs[i].br; MEM_BUSY = 0;
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl(),
          {27'd0, vecs[i].exp_frz, vecs[i].exp_frz, vecs[i].exp_bub, vecs[i].exp_flush, 1'b0});
      if (vecs[i].exp_frz) exp_stall++;
    end
    @(negedge CLK);
    clear_inputs();
    #1 chk("table_stall_cycles", STALL_CYCLES, 32'(exp_stall));

    // Interlock mode: producer of $5 in EXE, then MEM, then gone -> two stall cycles.
    FORWARD_EN = 0; SRC1_ID = 5; SRC2_ID = 2; SRC2_VALID_ID = 1;
    DEST_EXE = 5; WRITE_BACK_EN_EXE = 1;
    #1 chk("ilock_c1", {31'd0, PC_FREEZE}, 32'd1);
    @(negedge CLK);
    DEST_EXE = 0; WRITE_BACK_EN_EXE = 0; DEST_MEM = 5; WRITE_BACK_EN_MEM = 1;
    #1 chk("ilock_c2", {31'd0, PC_FREEZE}, 32'd1);
    @(negedge CLK);
    DEST_MEM = 0; WRITE_BACK_EN_MEM = 0;
    #1 chk("ilock_c3", ctl(), 32'd0);
    exp_stall += 2;
    chk("ilock_stall_cycles", STALL_CYCLES, 32'(exp_stall));
    @(negedge CLK);
    clear_inputs();

    // Memory wait of 5 cycles with a branch held (must be masked); branch honoured on exit.
    for (int i = 0; i < 5; i++) begin
      MEM_BUSY = 1; BRANCH_TAKEN_EXE = 1;
      #1 chk($sformatf("mwait_c%0d", i), ctl(), 32'b11001);
      @(negedge CLK);
    end
    MEM_BUSY = 0;
    exp_stall += 5;
    #1;
    chk("mwait_exit_ctl", ctl(), 32'b00110);
    chk("mwait_stall_cycles", STALL_CYCLES, 32'(exp_stall));
    chk("mwait_timeout", {31'd0, MEM_TIMEOUT}, 32'd0);
    @(negedge CLK);
    clear_inputs();
    #1 chk("mwait_after_state", 32'(dut.state_q), 32'(HZ_RUN));

    // Reset in the middle of a memory wait.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      MEM_BUSY = 1;
    end
    @(negedge CLK);
    RST = 1; SRC1_ID = 8; DEST_EXE = 8; WRITE_BACK_EN_EXE = 1; MEM_READ_EXE = 1;
    #1 chk("rst_mid_ctl", ctl(), 32'd0);
    @(negedge CLK);
    #1;
    chk("rst_mid_state", 32'(dut.state_q), 32'(HZ_RUN));
    chk("rst_mid_stall", STALL_CYCLES, 32'd0);
    chk("rst_mid_sat_stall", {28'd0, s_stall}, 32'd0);
    RST = 0;
    clear_inputs();
    exp_stall = 0;
    #1 chk("rst_mid_release_ctl", ctl(), 32'd0);

    // Watchdog: 20 busy cycles; MEM_TIMEOUT appears after the 16th edge.
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      MEM_BUSY = 1;
      #1;
      chk($sformatf("tmo_ctl_%0d", i), ctl(), 32'b11001);
      chk($sformatf("tmo_flag_%0d", i), {31'd0, MEM_TIMEOUT}, (i >= 17) ? 32'd1 : 32'd0);
      if (i == 15) chk("sat_stall_14", {28'd0, s_stall}, 32'd14);
      if (i == 20) chk("sat_ctl", {27'd0, s_pc, s_ifid, s_bub, s_flush, s_pipe}, 32'b11001);
    end
    @(negedge CLK);
    MEM_BUSY = 0;
    #1;
    chk("tmo_exit_ctl", ctl(), 32'd0);
    chk("tmo_stall_cycles", STALL_CYCLES, 32'd20);
    chk("sat_stall_no_wrap", {28'd0, s_stall}, 32'd15);
    repeat (3) @(negedge CLK);
    #1;
    chk("tmo_sticky", {31'd0, MEM_TIMEOUT}, 32'd1);
    chk("sat_tmo_sticky", {31'd0, s_tmo}, 32'd1);
    chk("tmo_back_to_run", 32'(dut.state_q), 32'(HZ_RUN));
    do_reset();
    #1 chk("tmo_cleared_by_reset", {31'd0, MEM_TIMEOUT}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
